// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the fetch/data memory-port arbiter: FSM state
// encoding, last-grant encoding and the word access format code.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SERVE_FETCH = 2'd1,
    ST_SERVE_DATA  = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  localparam logic [2:0] FORMAT_WORD = 3'b010;

endpackage

// File: rtl/bus_arbiter.sv
// Two-requester arbiter (instruction fetch + data load/store) onto one
// shared memory port. Ties are broken round-robin; the winning request is
// latched so the memory port never follows live requester inputs.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fetch_request,
  input  logic [ADDR_WIDTH-1:0] i_fetch_address,
  output logic                  o_fetch_ready,
  output logic [DATA_WIDTH-1:0] o_fetch_read_data,
  input  logic                  i_data_request,
  input  logic                  i_data_write,
  input  logic [ADDR_WIDTH-1:0] i_data_address,
  input  logic [DATA_WIDTH-1:0] i_data_write_data,
  input  logic [2:0]            i_data_format,
  output logic                  o_data_ready,
  output logic [DATA_WIDTH-1:0] o_data_read_data,
  output logic                  o_mem_request,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  output logic [2:0]            o_mem_format,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  state_e                  r_state;
  state_e                  w_state_next;
  grant_e                  r_last_grant;
  logic                    w_grant_fetch;
  logic                    w_grant_data;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [DATA_WIDTH-1:0]   r_write_data;
  logic [2:0]              r_format;

  // State register and round-robin history; last_grant starts at FETCH so data wins the first tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_FETCH;
    end else begin
      r_state <= w_state_next;
      if (w_grant_data)
        r_last_grant <= GRANT_DATA;
      else if (w_grant_fetch)
        r_last_grant <= GRANT_FETCH;
    end
  end

  // Next-state logic: grant from IDLE, hold while memory stalls, return on mem_ready
  always_comb begin
    w_state_next  = r_state;
    w_grant_fetch = 1'b0;
    w_grant_data  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_fetch = i_fetch_request && (!i_data_request || (r_last_grant == GRANT_DATA));
        w_grant_data  = i_data_request && (!i_fetch_request || (r_last_grant == GRANT_FETCH));
        if (w_grant_fetch)
          w_state_next = ST_SERVE_FETCH;
        else if (w_grant_data)
          w_state_next = ST_SERVE_DATA;
      end
      ST_SERVE_FETCH, ST_SERVE_DATA: begin
        if (i_mem_ready)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Capture the granted request; fetches are always word reads
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write      <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_format     <= '0;
    end else if (w_grant_fetch) begin
      r_write      <= 1'b0;
      r_address    <= i_fetch_address;
      r_write_data <= '0;
      r_format     <= FORMAT_WORD;
    end else if (w_grant_data) begin
      r_write      <= i_data_write;
      r_address    <= i_data_address;
      r_write_data <= i_data_write_data;
      r_format     <= i_data_format;
    end
  end

  // Output mux: memory port from latched registers, ready/read data only for the served requester
  always_comb begin
    o_mem_request     = (r_state != ST_IDLE);
    o_mem_write       = r_write;
    o_mem_address     = r_address;
    o_mem_write_data  = r_write_data;
    o_mem_format      = r_format;
    o_fetch_ready     = (r_state == ST_SERVE_FETCH) && i_mem_ready;
    o_data_ready      = (r_state == ST_SERVE_DATA) && i_mem_ready;
    o_fetch_read_data = o_fetch_ready ? i_mem_read_data : '0;
    o_data_read_data  = o_data_ready ? i_mem_read_data : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a wait-state memory responder and a
// scoreboard of expected completions popped on every ready pulse.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_request;
  logic [AW-1:0] fetch_address;
  logic          fetch_ready;
  logic [DW-1:0] fetch_read_data;
  logic          data_request;
  logic          data_write;
  logic [AW-1:0] data_address;
  logic [DW-1:0] data_write_data;
  logic [2:0]    data_format;
  logic          data_ready;
  logic [DW-1:0] data_read_data;
  logic          mem_request;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [2:0]    mem_format;
  logic          mem_ready;
  logic [DW-1:0] mem_read_data;

  int checks   = 0;
  int failures = 0;

  // memory responder configuration
  int wait_cfg    = 0;
  int wait_cnt    = 0;
  bit force_ready = 1'b0;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [2:0]  fmt;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_fetch_request   (fetch_request),
    .i_fetch_address   (fetch_address),
    .o_fetch_ready     (fetch_ready),
    .o_fetch_read_data (fetch_read_data),
    .i_data_request    (data_request),
    .i_data_write      (data_write),
    .i_data_address    (data_address),
    .i_data_write_data (data_write_data),
    .i_data_format     (data_format),
    .o_data_ready      (data_ready),
    .o_data_read_data  (data_read_data),
    .o_mem_request     (mem_request),
    .o_mem_write       (mem_write),
    .o_mem_address     (mem_address),
    .o_mem_write_data  (mem_write_data),
    .o_mem_format      (mem_format),
    .i_mem_ready       (mem_ready),
    .i_mem_read_data   (mem_read_data)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers after wait_cfg stall cycles, driven just after the edge
  always @(posedge clk) begin
    #1;
    if (force_ready) begin
      mem_ready     = 1'b1;
      mem_read_data = 32'hFFFF_FFFF;
    end else if (mem_request) begin
      if (wait_cnt >= wait_cfg) begin
        mem_ready     = 1'b1;
        mem_read_data = mem_model(mem_address);
        wait_cnt      = 0;
      end else begin
        mem_ready     = 1'b0;
        mem_read_data = 32'h0BAD_0BAD;
        wait_cnt      = wait_cnt + 1;
      end
    end else begin
      mem_ready     = 1'b0;
      mem_read_data = 32'h0BAD_0BAD;
      wait_cnt      = 0;
    end
  end

  // Scoreboard monitor: every ready pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (rst_n && (fetch_ready || data_ready)) begin
      exp_t e;
      check("ready_exclusive", {31'd0, fetch_ready & data_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_ready", {30'd0, fetch_ready, data_ready}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("grant_kind", {31'd0, data_ready}, {31'd0, e.is_data});
        check("mem_address", mem_address, e.addr);
        check("mem_write", {31'd0, mem_write}, {31'd0, e.wr});
        check("mem_format", {29'd0, mem_format}, {29'd0, e.fmt});
        check("mem_write_data", mem_write_data, e.wdata);
        if (e.is_data)
          check("data_read_data", data_read_data, mem_model(e.addr));
        else
          check("fetch_read_data", fetch_read_data, mem_model(e.addr));
        $display("txn %s addr=0x%08h wr=%0d fmt=%03b rdata=0x%08h",
                 data_ready ? "DATA " : "FETCH", mem_address, mem_write, mem_format,
                 data_ready ? data_read_data : fetch_read_data);
      end
    end
  end

  function automatic exp_t mk(input bit d, input logic [31:0] a, input bit w,
                              input logic [31:0] wd, input logic [2:0] f);
    exp_t e;
    e.is_data = d; e.addr = a; e.wr = w; e.wdata = wd; e.fmt = f;
    return e;
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    fetch_request = 0; fetch_address = 0;
    data_request = 0; data_write = 0; data_address = 0;
    data_write_data = 0; data_format = 0;
    mem_ready = 0; mem_read_data = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_mem_request", {31'd0, mem_request}, 32'd0);
    check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_format", {29'd0, mem_format}, 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    // spurious mem_ready in IDLE is ignored
    force_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_mem_request", {31'd0, mem_request}, 32'd0);
      check("spur_readies", {30'd0, fetch_ready, data_ready}, 32'd0);
    end
    @(posedge clk); #2; force_ready = 1'b0;

    // both requesting continuously: D,F,D,F,D,F (first tie after reset goes to data)
    wait_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk(1, 32'h0000_0200, 0, 32'h0, 3'b100));
      sb_q.push_back(mk(0, 32'h0000_0100, 0, 32'h0, FORMAT_WORD));
    end
    @(posedge clk); #2;
    fetch_request = 1; fetch_address = 32'h0000_0100;
    data_request = 1; data_address = 32'h0000_0200; data_format = 3'b100;
    n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (fetch_ready || data_ready) n++;
    end
    check("alt_count", n, 6);
    @(posedge clk); #2;
    fetch_request = 0; data_request = 0;

    // fetch with 2 wait cycles
    wait_cfg = 2;
    sb_q.push_back(mk(0, 32'h0000_0040, 0, 32'h0, FORMAT_WORD));
    @(posedge clk); #2;
    fetch_request = 1; fetch_address = 32'h0000_0040;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_request && !fetch_ready) check("fetch_wait_write", {31'd0, mem_write}, 32'd0);
      if (fetch_ready) begin n++; break; end
    end
    check("fetch_done", n, 1);
    @(posedge clk); #2; fetch_request = 0;
    @(negedge clk);
    check("fetch_single_pulse", {31'd0, fetch_ready}, 32'd0);

    // data write, zero wait
    wait_cfg = 0;
    sb_q.push_back(mk(1, 32'h0000_1000, 1, 32'hDEAD_BEEF, 3'b000));
    @(posedge clk); #2;
    data_request = 1; data_write = 1; data_address = 32'h0000_1000;
    data_write_data = 32'hDEAD_BEEF; data_format = 3'b000;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_ready) begin
        check("write_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        n++; break;
      end
    end
    check("write_done", n, 1);
    @(posedge clk); #2; data_request = 0; data_write = 0; data_write_data = 0;

    // data read whose live address changes while the memory stalls
    wait_cfg = 4;
    sb_q.push_back(mk(1, 32'h0000_1000, 0, 32'h0, 3'b010));
    @(posedge clk); #2;
    data_request = 1; data_address = 32'h0000_1000; data_format = 3'b010;
    @(posedge clk); #2;
    @(posedge clk); #2; data_address = 32'h0000_2000;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_ready) begin n++; break; end
      check("hold_mem_address", mem_address, 32'h0000_1000);
      check("hold_read_data_zero", data_read_data, 32'd0);
    end
    check("hold_done", n, 1);
    @(posedge clk); #2; data_request = 0;

    // reset during a stalled fetch aborts it; first tie afterwards goes to data
    wait_cfg = 8;
    @(posedge clk); #2;
    fetch_request = 1; fetch_address = 32'h0000_0080;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_mem_request", {31'd0, mem_request}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_request", {31'd0, mem_request}, 32'd0);
    check("abort_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    check("abort_latched_addr", mem_address, 32'd0);
    fetch_request = 0;
    @(negedge clk);
    @(posedge clk); #2; rst_n = 1'b1;
    wait_cfg = 0;
    sb_q.push_back(mk(1, 32'h0000_0300, 0, 32'h0, 3'b001));
    fetch_request = 1; fetch_address = 32'h0000_0180;
    data_request = 1; data_address = 32'h0000_0300; data_format = 3'b001;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_ready || data_ready) begin n++; break; end
    end
    check("post_rst_tie", n, 1);
    @(posedge clk); #2; fetch_request = 0; data_request = 0;
    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
